// File: rtl/ternary_adder_pipe.sv
// ternary_adder_pipe: pipelined balanced-ternary adder/subtractor.
// The carry chain is cut into SEG-trit segments, one per pipeline stage.
// Upper operand trits ride along until their stage, and finished low sum
// trits ride forward, so the last stage presents one coherent result word.
// Optional feature: define TERNARY_ADD_SAT_EN to saturate out_sum on overflow.
// Without it the sum wraps and out_cout carries the excess.

package ternary_adder_pipe_pkg;
  // Two-bit signed encoding of one trit; 2'b10 is unused and reads as zero.
  typedef logic [1:0] trit_t;

  localparam trit_t T_ZERO = 2'b00;
  localparam trit_t T_POS  = 2'b01;
  localparam trit_t T_NEG  = 2'b11;

  function automatic logic signed [2:0] trit_val(input trit_t t);
    case (t)
      T_POS:   trit_val = 3'sd1;
      T_NEG:   trit_val = -3'sd1;
      default: trit_val = 3'sd0;
    endcase
  endfunction

  function automatic trit_t val_trit(input logic signed [2:0] v);
    if (v > 3'sd0)      val_trit = T_POS;
    else if (v < 3'sd0) val_trit = T_NEG;
    else                val_trit = T_ZERO;
  endfunction

  function automatic trit_t trit_neg(input trit_t t);
    trit_neg = val_trit(-trit_val(t));
  endfunction

  // Returns {carry, sum}; a+b+c spans -3..3 and folds back into one trit.
  function automatic logic [3:0] trit_full_add(input trit_t a, input trit_t b, input trit_t c);
    logic signed [2:0] s;
    s = trit_val(a) + trit_val(b) + trit_val(c);
    if (s > 3'sd1)       trit_full_add = {T_POS, val_trit(s - 3'sd3)};
    else if (s < -3'sd1) trit_full_add = {T_NEG, val_trit(s + 3'sd3)};
    else                 trit_full_add = {T_ZERO, val_trit(s)};
  endfunction
endpackage

module ternary_adder_pipe
  import ternary_adder_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SEG   = 3,
  parameter int TAGW  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  trit_t [WIDTH-1:0]      in_a,
  input  trit_t [WIDTH-1:0]      in_b,
  input  trit_t                  in_cin,
  input  logic                   in_sub,
  input  logic [TAGW-1:0]        in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output trit_t [WIDTH-1:0]      out_sum,
  output trit_t                  out_cout,
  output logic                   out_ovf,
  output logic [TAGW-1:0]        out_tag
);

  localparam int NSTAGE = (WIDTH + SEG - 1) / SEG;

  typedef trit_t [WIDTH-1:0] word_t;

  // Stage registers: stage k holds the result of segments 0..k plus the
  // operand trits still waiting for later stages.
  word_t           st_a   [NSTAGE];
  word_t           st_b   [NSTAGE];
  word_t           st_sum [NSTAGE];
  trit_t           st_c   [NSTAGE];
  logic            st_v   [NSTAGE];
  logic [TAGW-1:0] st_tag [NSTAGE];

  word_t           nx_a   [NSTAGE];
  word_t           nx_b   [NSTAGE];
  word_t           nx_sum [NSTAGE];
  trit_t           nx_c   [NSTAGE];
  logic            nx_v   [NSTAGE];
  logic [TAGW-1:0] nx_tag [NSTAGE];

  word_t           neg_b;
  word_t           sa, sb, ss;
  trit_t           c;
  logic            sv;
  logic [TAGW-1:0] stag;
  int              p;
  logic            en;

  // One global enable: the whole pipe moves together or holds together.
  assign en       = !st_v[NSTAGE-1] || out_ready;
  assign in_ready = en;

  // Subtraction negates B trit-wise before it enters the pipe.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      neg_b[i] = trit_neg(in_b[i]);
    end
  end

  // Next-state of every stage: add this stage's segment onto the incoming carry.
  always_comb begin
    sa   = '0;
    sb   = '0;
    ss   = '0;
    c    = T_ZERO;
    sv   = 1'b0;
    stag = '0;
    p    = 0;
    for (int k = 0; k < NSTAGE; k++) begin
      p    = (k == 0) ? 0 : k - 1;
      sa   = st_a[p];
      sb   = st_b[p];
      ss   = st_sum[p];
      c    = st_c[p];
      sv   = st_v[p];
      stag = st_tag[p];
      if (k == 0) begin
        sa   = in_a;
        sb   = in_sub ? neg_b : in_b;
        ss   = '0;
        c    = in_cin;
        sv   = in_valid;
        stag = in_tag;
      end
      for (int i = 0; i < WIDTH; i++) begin
        if (i >= k * SEG && i < (k + 1) * SEG) begin
          {c, ss[i]} = trit_full_add(sa[i], sb[i], c);
        end
      end
`ifdef TERNARY_ADD_SAT_EN
      if (k == NSTAGE - 1) begin
        if (c == T_POS)      ss = {WIDTH{T_POS}};
        else if (c == T_NEG) ss = {WIDTH{T_NEG}};
      end
`endif
      nx_a[k]   = sa;
      nx_b[k]   = sb;
      nx_sum[k] = ss;
      nx_c[k]   = c;
      nx_v[k]   = sv;
      nx_tag[k] = stag;
    end
  end

  // Pipeline registers: reset drops every in-flight beat, otherwise advance on enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NSTAGE; k++) begin
        st_a[k]   <= '0;
        st_b[k]   <= '0;
        st_sum[k] <= '0;
        st_c[k]   <= T_ZERO;
        st_v[k]   <= 1'b0;
        st_tag[k] <= '0;
      end
    end else if (en) begin
      for (int k = 0; k < NSTAGE; k++) begin
        st_a[k]   <= nx_a[k];
        st_b[k]   <= nx_b[k];
        st_sum[k] <= nx_sum[k];
        st_c[k]   <= nx_c[k];
        st_v[k]   <= nx_v[k];
        st_tag[k] <= nx_tag[k];
      end
    end
  end

  assign out_valid = st_v[NSTAGE-1];
  assign out_sum   = st_sum[NSTAGE-1];
  assign out_cout  = st_c[NSTAGE-1];
  assign out_ovf   = (st_c[NSTAGE-1] != T_ZERO);
  assign out_tag   = st_tag[NSTAGE-1];

endmodule

// File: tb/tb_ternary_adder_pipe.sv
// Testbench for ternary_adder_pipe: directed table, random stream with
// back-pressure, reset flush, and corner operands on two other geometries.
// Honours TERNARY_ADD_SAT_EN when computing expected overflow sums.

module tb_ternary_adder_pipe;
  import ternary_adder_pipe_pkg::*;

  logic clk;
  logic rst;

  // Main instance: WIDTH=8, SEG=3 (three stages).
  logic         in_valid;
  logic         in_ready;
  trit_t [7:0]  in_a;
  trit_t [7:0]  in_b;
  trit_t        in_cin;
  logic         in_sub;
  logic [3:0]   in_tag;
  logic         out_valid;
  logic         out_ready;
  trit_t [7:0]  out_sum;
  trit_t        out_cout;
  logic         out_ovf;
  logic [3:0]   out_tag;

  // Side instances: WIDTH=7/SEG=3 and WIDTH=9/SEG=9.
  logic         s_valid;
  logic         s_oready;
  trit_t        s_cin;
  logic         s_sub;
  logic [3:0]   s_tag;
  trit_t [6:0]  w7_a, w7_b, w7_sum;
  trit_t [8:0]  w9_a, w9_b, w9_sum;
  logic         w7_in_ready, w7_out_valid, w7_ovf;
  logic         w9_in_ready, w9_out_valid, w9_ovf;
  trit_t        w7_cout, w9_cout;
  logic [3:0]   w7_tag, w9_tag;

  int n_compared;
  int n_mismatched;

  ternary_adder_pipe #(.WIDTH(8), .SEG(3), .TAGW(4)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf), .out_tag(out_tag)
  );

  ternary_adder_pipe #(.WIDTH(7), .SEG(3), .TAGW(4)) u_w7 (
    .clk(clk), .rst(rst),
    .in_valid(s_valid), .in_ready(w7_in_ready),
    .in_a(w7_a), .in_b(w7_b), .in_cin(s_cin), .in_sub(s_sub), .in_tag(s_tag),
    .out_valid(w7_out_valid), .out_ready(s_oready),
    .out_sum(w7_sum), .out_cout(w7_cout), .out_ovf(w7_ovf), .out_tag(w7_tag)
  );

  ternary_adder_pipe #(.WIDTH(9), .SEG(9), .TAGW(4)) u_w9 (
    .clk(clk), .rst(rst),
    .in_valid(s_valid), .in_ready(w9_in_ready),
    .in_a(w9_a), .in_b(w9_b), .in_cin(s_cin), .in_sub(s_sub), .in_tag(s_tag),
    .out_valid(w9_out_valid), .out_ready(s_oready),
    .out_sum(w9_sum), .out_cout(w9_cout), .out_ovf(w9_ovf), .out_tag(w9_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Integer to balanced-ternary trits (16 trits, LSB first).
  function automatic logic [31:0] enc(input int v);
    logic [31:0] r;
    int x, m;
    r = '0;
    x = v;
    for (int i = 0; i < 16; i++) begin
      m = x % 3;
      if (m < 0) m += 3;
      if (m == 1) begin
        r[2*i +: 2] = T_POS;
        x = (x - 1) / 3;
      end else if (m == 2) begin
        r[2*i +: 2] = T_NEG;
        x = (x + 1) / 3;
      end else begin
        x = x / 3;
      end
    end
    return r;
  endfunction

  // Balanced-ternary trits back to an integer.
  function automatic int dec(input logic [31:0] t, input int w);
    int acc, pw;
    acc = 0;
    pw  = 1;
    for (int i = 0; i < w; i++) begin
      if (t[2*i +: 2] == T_POS)      acc += pw;
      else if (t[2*i +: 2] == T_NEG) acc -= pw;
      pw *= 3;
    end
    return acc;
  endfunction

  function automatic trit_t cin_trit(input int c);
    if (c > 0)      return T_POS;
    else if (c < 0) return T_NEG;
    else            return T_ZERO;
  endfunction

  // Integer reference: exact sum folded into the balanced range of w trits.
  task automatic ref_add(input int a, input int b, input int cin, input bit sub,
                         input int w, output int s, output int co);
    int m, h, t;
    m = 1;
    for (int i = 0; i < w; i++) m *= 3;
    h  = (m - 1) / 2;
    t  = a + (sub ? -b : b) + cin;
    co = 0;
    if (t > h) begin
      t -= m;
      co = 1;
    end else if (t < -h) begin
      t += m;
      co = -1;
    end
    s = t;
`ifdef TERNARY_ADD_SAT_EN
    if (co == 1)       s = h;
    else if (co == -1) s = -h;
`endif
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  typedef struct {
    int         a;
    int         b;
    int         cin;
    bit         sub;
    logic [3:0] tag;
    int         sum_wrap;
    int         sum_sat;
    int         cout;
  } vec_t;

  vec_t vecs[10];

  task automatic applyStimulus(input int a, input int b, input int cin,
                               input bit sub, input logic [3:0] tag);
    logic [31:0] t;
    t        = enc(a);
    in_a     = t[15:0];
    t        = enc(b);
    in_b     = t[15:0];
    in_cin   = cin_trit(cin);
    in_sub   = sub;
    in_tag   = tag;
    in_valid = 1'b1;
  endtask

  task automatic run_vector(input vec_t v);
    int lat, exp_sum;
`ifdef TERNARY_ADD_SAT_EN
    exp_sum = v.sum_sat;
`else
    exp_sum = v.sum_wrap;
`endif
    @(negedge clk);
    out_ready = 1'b1;
    applyStimulus(v.a, v.b, v.cin, v.sub, v.tag);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("vec_latency", lat, 3);
    checkOutput("vec_sum", dec(32'(out_sum), 8), exp_sum);
    checkOutput("vec_cout", dec(32'(out_cout), 1), v.cout);
    checkOutput("vec_ovf", int'(out_ovf), int'(v.cout != 0));
    checkOutput("vec_tag", int'(out_tag), int'(v.tag));
  endtask

  task automatic run_small(input int a7, input int b7, input int a9, input int b9,
                           input int cin, input bit sub);
    logic [31:0] t;
    int lat, s, co;
    @(negedge clk);
    t = enc(a7); w7_a = t[13:0];
    t = enc(b7); w7_b = t[13:0];
    t = enc(a9); w9_a = t[17:0];
    t = enc(b9); w9_b = t[17:0];
    s_cin   = cin_trit(cin);
    s_sub   = sub;
    s_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    checkOutput("w9_latency1_valid", int'(w9_out_valid), 1);
    ref_add(a9, b9, cin, sub, 9, s, co);
    checkOutput("w9_sum", dec(32'(w9_sum), 9), s);
    checkOutput("w9_cout", dec(32'(w9_cout), 1), co);
    checkOutput("w9_ovf", int'(w9_ovf), int'(co != 0));
    lat = 1;
    while (!w7_out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("w7_latency", lat, 3);
    ref_add(a7, b7, cin, sub, 7, s, co);
    checkOutput("w7_sum", dec(32'(w7_sum), 7), s);
    checkOutput("w7_cout", dec(32'(w7_cout), 1), co);
    checkOutput("w7_ovf", int'(w7_ovf), int'(co != 0));
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int q_sum[$], q_cout[$], q_tag[$];
    int sent, recv, cyc, pend_sum, pend_cout, hold_sum, hold_tag;
    int ra, rb, rc, lat;
    bit rs, acc, hold;
    int c7[5], c9[5];

    n_compared   = 0;
    n_mismatched = 0;

    //          a      b     cin sub tag   wrap   sat   cout
    vecs[0] = '{5,     7,     0, 1'b0, 4'h1,  12,    12,    0};
    vecs[1] = '{5,     7,     1, 1'b1, 4'h2,  -1,    -1,    0};
    vecs[2] = '{3280,  1,     0, 1'b0, 4'h3,  -3280, 3280,  1};
    vecs[3] = '{-3280, 1,     0, 1'b1, 4'h4,  3280,  -3280, -1};
    vecs[4] = '{0,     0,    -1, 1'b0, 4'h5,  -1,    -1,    0};
    vecs[5] = '{3280,  3280,  1, 1'b0, 4'h6,  0,     3280,  1};
    vecs[6] = '{100,   250,   0, 1'b1, 4'h7,  -150,  -150,  0};
    vecs[7] = '{-1000, -2000, 0, 1'b0, 4'h8,  -3000, -3000, 0};
    vecs[8] = '{1234,  -2047, 0, 1'b1, 4'h9,  -3280, 3280,  1};
    vecs[9] = '{-3280, 3280, -1, 1'b1, 4'hA,  0,     -3280, -1};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = T_ZERO;
    in_sub    = 1'b0;
    in_tag    = '0;
    out_ready = 1'b1;
    s_valid   = 1'b0;
    s_oready  = 1'b1;
    s_cin     = T_ZERO;
    s_sub     = 1'b0;
    s_tag     = 4'hC;
    w7_a = '0; w7_b = '0; w9_a = '0; w9_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    checkOutput("reset_out_valid", int'(out_valid), 0);
    checkOutput("reset_out_sum", int'(out_sum), 0);
    checkOutput("reset_out_cout", int'(out_cout), 0);
    checkOutput("reset_out_ovf", int'(out_ovf), 0);
    checkOutput("reset_out_tag", int'(out_tag), 0);
    checkOutput("reset_in_ready", int'(in_ready), 1);

    for (int i = 0; i < 10; i++) run_vector(vecs[i]);

    // Random stream with pseudo-random back-pressure.
    sent = 0; recv = 0; cyc = 0; acc = 0; hold = 0;
    hold_sum = 0; hold_tag = 0; pend_sum = 0; pend_cout = 0;
    while (recv < 10 && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (hold) begin
        checkOutput("hold_valid", int'(out_valid), 1);
        checkOutput("hold_sum", dec(32'(out_sum), 8), hold_sum);
        checkOutput("hold_tag", int'(out_tag), hold_tag);
      end
      if (acc) in_valid = 1'b0;
      acc = 0;
      if (!in_valid && sent < 10) begin
        ra = int'($urandom_range(0, 6560)) - 3280;
        rb = int'($urandom_range(0, 6560)) - 3280;
        rc = int'($urandom_range(0, 2)) - 1;
        rs = bit'($urandom_range(0, 1));
        applyStimulus(ra, rb, rc, rs, 4'(sent));
        ref_add(ra, rb, rc, rs, 8, pend_sum, pend_cout);
      end
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (out_valid && out_ready) begin
        if (q_sum.size() == 0) begin
          checkOutput("stream_unexpected_beat", 1, 0);
        end else begin
          checkOutput("stream_sum", dec(32'(out_sum), 8), q_sum.pop_front());
          checkOutput("stream_cout", dec(32'(out_cout), 1), q_cout.pop_front());
          checkOutput("stream_tag", int'(out_tag), q_tag.pop_front());
        end
        recv++;
      end
      hold = out_valid && !out_ready;
      if (hold) begin
        hold_sum = dec(32'(out_sum), 8);
        hold_tag = int'(out_tag);
      end
      if (in_valid && in_ready) begin
        q_sum.push_back(pend_sum);
        q_cout.push_back(pend_cout);
        q_tag.push_back(sent);
        sent++;
        acc = 1;
      end
    end
    checkOutput("stream_received", recv, 10);
    checkOutput("stream_leftover", q_sum.size(), 0);

    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(negedge clk);

    // Reset with beats in flight; the third beat collides with reset.
    applyStimulus(100, 7, 1, 1'b0, 4'hD);
    @(negedge clk);
    applyStimulus(-50, 3, 0, 1'b1, 4'hE);
    @(negedge clk);
    applyStimulus(3280, 1, 0, 1'b0, 4'hF);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("flush_out_valid", int'(out_valid), 0);
    checkOutput("flush_out_sum", int'(out_sum), 0);
    checkOutput("flush_out_cout", int'(out_cout), 0);
    checkOutput("flush_out_ovf", int'(out_ovf), 0);
    checkOutput("flush_out_tag", int'(out_tag), 0);
    checkOutput("flush_in_ready", int'(in_ready), 1);
    rst      = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("flush_no_stale_beat", int'(out_valid), 0);
    end

    // Corner operands on the short-last-segment and single-stage geometries.
    c7 = '{1093, -1093, 0, 1, -1};
    c9 = '{9841, -9841, 0, 1, -1};
    for (int ai = 0; ai < 5; ai++) begin
      for (int bi = 0; bi < 5; bi++) begin
        for (int sb = 0; sb < 2; sb++) begin
          run_small(c7[ai], c7[bi], c9[ai], c9[bi], ((ai + bi) % 3) - 1, 1'(sb));
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
